// File: rtl/stopwatch_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : stopwatch_core
// Description : Centisecond stopwatch datapath. A prescaler divides clk down
//               to TICK_HZ and advances a BCD MM:SS.CC digit chain. The
//               display word (MM:SS or SS:CC) is registered for the FND scan
//               mux, and running/overflow status is reported for the LEDs.
//               Optional lap-freeze display: define STOPWATCH_LAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_core #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 100,
    parameter int PRESC   = CLK_HZ / TICK_HZ
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_md,
    input  logic        disp_md,
    input  logic        clr_on,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
    output logic        lap_act,
`endif
    output logic [15:0] disp_bcd,
    output logic        tick,
    output logic        running,
    output logic        ovf
);

    // Prescaler width; PRESC is required to be at least 2.
    localparam int            PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [3:0]    MAX_UNITS  = 4'd9;
    localparam logic [3:0]    MAX_TENS   = 4'd5;

    // Next value of one BCD digit on a carry-in; wraps at its limit.
    // The >= keeps an out-of-range digit from ever counting past the limit.
    function automatic logic [3:0] step_digit(input logic [3:0] v,
                                              input logic [3:0] lim);
        if (v >= lim) begin
            step_digit = 4'd0;
        end else begin
            step_digit = v + 4'd1;
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    cs_o_q,  cs_o_d;
    logic [3:0]    cs_t_q,  cs_t_d;
    logic [3:0]    sec_o_q, sec_o_d;
    logic [3:0]    sec_t_q, sec_t_d;
    logic [3:0]    min_o_q, min_o_d;
    logic [3:0]    min_t_q, min_t_d;
    logic          ovf_q,     ovf_d;
    logic          running_q, running_d;
    logic [15:0]   disp_q,    disp_d;

    // Combinational helpers
    logic          en;
    logic          at_term;
    logic          tick_c;
    logic          cy_cs_o;
    logic          cy_cs_t;
    logic          cy_sec_o;
    logic          cy_sec_t;
    logic          cy_min_o;
    logic          cy_min_t;
    logic [15:0]   live_mmss;
    logic [15:0]   live_sscc;

`ifdef STOPWATCH_LAP_EN
    logic          lap_act_q, lap_act_d;
    logic          frozen;
    logic [3:0]    snap_cs_o_q,  snap_cs_o_d;
    logic [3:0]    snap_cs_t_q,  snap_cs_t_d;
    logic [3:0]    snap_sec_o_q, snap_sec_o_d;
    logic [3:0]    snap_sec_t_q, snap_sec_t_d;
    logic [3:0]    snap_min_o_q, snap_min_o_d;
    logic [3:0]    snap_min_t_q, snap_min_t_d;
`endif

    // Enable, prescaler terminal-count detect and tick generation.
    always_comb begin
        en      = run_md & ~clr_on;
        at_term = (presc_q == PRESC_LAST);
        // Gated by rst so no tick is reported on a cycle whose edge resets.
        tick_c  = en & at_term & ~rst;
        presc_d = presc_q;
        if (clr_on) begin
            presc_d = '0;
        end else if (en) begin
            // Pausing simply stops this update, so the sub-tick phase survives.
            presc_d = at_term ? '0 : presc_q + 1'b1;
        end
    end

    // BCD digit chain: every carry ripples through on the same tick.
    always_comb begin
        cs_o_d   = cs_o_q;
        cs_t_d   = cs_t_q;
        sec_o_d  = sec_o_q;
        sec_t_d  = sec_t_q;
        min_o_d  = min_o_q;
        min_t_d  = min_t_q;
        ovf_d    = ovf_q;

        cy_cs_o  = tick_c   & (cs_o_q  >= MAX_UNITS);
        cy_cs_t  = cy_cs_o  & (cs_t_q  >= MAX_UNITS);
        cy_sec_o = cy_cs_t  & (sec_o_q >= MAX_UNITS);
        cy_sec_t = cy_sec_o & (sec_t_q >= MAX_TENS);
        cy_min_o = cy_sec_t & (min_o_q >= MAX_UNITS);
        cy_min_t = cy_min_o & (min_t_q >= MAX_TENS);

        if (clr_on) begin
            cs_o_d  = 4'd0;
            cs_t_d  = 4'd0;
            sec_o_d = 4'd0;
            sec_t_d = 4'd0;
            min_o_d = 4'd0;
            min_t_d = 4'd0;
            ovf_d   = 1'b0;
        end else begin
            if (tick_c)   cs_o_d  = step_digit(cs_o_q,  MAX_UNITS);
            if (cy_cs_o)  cs_t_d  = step_digit(cs_t_q,  MAX_UNITS);
            if (cy_cs_t)  sec_o_d = step_digit(sec_o_q, MAX_UNITS);
            if (cy_sec_o) sec_t_d = step_digit(sec_t_q, MAX_TENS);
            if (cy_sec_t) min_o_d = step_digit(min_o_q, MAX_UNITS);
            if (cy_min_o) min_t_d = step_digit(min_t_q, MAX_TENS);
            // Carry out of the top digit means 59:59.99 rolled to zero.
            if (cy_min_t) ovf_d = 1'b1;
        end

        running_d = en;
    end

`ifdef STOPWATCH_LAP_EN
    // Lap toggle and digit snapshot; clear also drops out of lap view.
    always_comb begin
        snap_cs_o_d  = snap_cs_o_q;
        snap_cs_t_d  = snap_cs_t_q;
        snap_sec_o_d = snap_sec_o_q;
        snap_sec_t_d = snap_sec_t_q;
        snap_min_o_d = snap_min_o_q;
        snap_min_t_d = snap_min_t_q;
        lap_act_d    = lap_act_q;
        if (clr_on) begin
            lap_act_d = 1'b0;
        end else if (lap) begin
            lap_act_d = ~lap_act_q;
            if (!lap_act_q) begin
                snap_cs_o_d  = cs_o_q;
                snap_cs_t_d  = cs_t_q;
                snap_sec_o_d = sec_o_q;
                snap_sec_t_d = sec_t_q;
                snap_min_o_d = min_o_q;
                snap_min_t_d = min_t_q;
            end
        end
        // Show the snapshot only while lap view is both active and staying
        // active; on the entering cycle the live digits equal the snapshot,
        // and on the leaving cycle live digits are loaded immediately.
        frozen = lap_act_q & lap_act_d;
    end
`endif

    // Display source select; the result is registered into disp_q.
    always_comb begin
`ifdef STOPWATCH_LAP_EN
        if (frozen) begin
            live_mmss = {snap_min_t_q, snap_min_o_q, snap_sec_t_q, snap_sec_o_q};
            live_sscc = {snap_sec_t_q, snap_sec_o_q, snap_cs_t_q, snap_cs_o_q};
        end else begin
            live_mmss = {min_t_q, min_o_q, sec_t_q, sec_o_q};
            live_sscc = {sec_t_q, sec_o_q, cs_t_q, cs_o_q};
        end
`else
        live_mmss = {min_t_q, min_o_q, sec_t_q, sec_o_q};
        live_sscc = {sec_t_q, sec_o_q, cs_t_q, cs_o_q};
`endif
        disp_d = disp_md ? live_sscc : live_mmss;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            cs_o_q    <= 4'd0;
            cs_t_q    <= 4'd0;
            sec_o_q   <= 4'd0;
            sec_t_q   <= 4'd0;
            min_o_q   <= 4'd0;
            min_t_q   <= 4'd0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            disp_q    <= 16'h0000;
`ifdef STOPWATCH_LAP_EN
            lap_act_q    <= 1'b0;
            snap_cs_o_q  <= 4'd0;
            snap_cs_t_q  <= 4'd0;
            snap_sec_o_q <= 4'd0;
            snap_sec_t_q <= 4'd0;
            snap_min_o_q <= 4'd0;
            snap_min_t_q <= 4'd0;
`endif
        end else begin
            presc_q   <= presc_d;
            cs_o_q    <= cs_o_d;
            cs_t_q    <= cs_t_d;
            sec_o_q   <= sec_o_d;
            sec_t_q   <= sec_t_d;
            min_o_q   <= min_o_d;
            min_t_q   <= min_t_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
            disp_q    <= disp_d;
`ifdef STOPWATCH_LAP_EN
            lap_act_q    <= lap_act_d;
            snap_cs_o_q  <= snap_cs_o_d;
            snap_cs_t_q  <= snap_cs_t_d;
            snap_sec_o_q <= snap_sec_o_d;
            snap_sec_t_q <= snap_sec_t_d;
            snap_min_o_q <= snap_min_o_d;
            snap_min_t_q <= snap_min_t_d;
`endif
        end
    end

    assign disp_bcd = disp_q;
    assign tick     = tick_c;
    assign running  = running_q;
    assign ovf      = ovf_q;
`ifdef STOPWATCH_LAP_EN
    assign lap_act  = lap_act_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_core
// Description : Scoreboard bench for stopwatch_core with PRESC = 10. The
//               driver updates an arithmetic reference model (total
//               centiseconds + prescaler phase) and queues the expected
//               outputs; a negedge monitor pops and compares every cycle.
//               Lap tests are included when STOPWATCH_LAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_core;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int PRESC   = CLK_HZ / TICK_HZ;
    localparam int FULL    = 360000;   // centiseconds in 60 minutes

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_md = 1'b0;
    logic        disp_md = 1'b0;
    logic        clr_on = 1'b0;
    logic [15:0] disp_bcd;
    logic        tick;
    logic        running;
    logic        ovf;
`ifdef STOPWATCH_LAP_EN
    logic        lap = 1'b0;
    logic        lap_act;
`endif

    stopwatch_core #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run_md   (run_md),
        .disp_md  (disp_md),
        .clr_on   (clr_on),
`ifdef STOPWATCH_LAP_EN
        .lap      (lap),
        .lap_act  (lap_act),
`endif
        .disp_bcd (disp_bcd),
        .tick     (tick),
        .running  (running),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        bit          tick;
        bit          running;
        bit          ovf;
        logic [15:0] disp;
        bit          lap_act;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   n_ticks  = 0;

    // Reference model state (values the DUT registers hold right now)
    int          m_phase  = 0;
    int          m_centis = 0;
    int          m_snap   = 0;
    bit          m_ovf    = 0;
    bit          m_run    = 0;
    bit          m_lap    = 0;
    bit          m_known  = 0;
    logic [15:0] m_disp   = 16'h0000;

    function automatic logic [15:0] fmt(input int c, input bit sscc);
        int mn, s, cc;
        mn = c / 6000;
        s  = (c / 100) % 60;
        cc = c % 100;
        if (sscc) return {4'(s / 10), 4'(s % 10), 4'(cc / 10), 4'(cc % 10)};
        return {4'(mn / 10), 4'(mn % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %h required %h", name, $time, act, req);
        end
    endtask

    // One clock cycle of stimulus; the model produces the expected outputs
    // for this cycle and then advances to the state after the next edge.
    task automatic cyc(input bit i_rst, input bit i_run, input bit i_dmd,
                       input bit i_clr, input bit i_lap);
        exp_t e;
        bit   en, nl;
        @(posedge clk);
        #1;
        rst     = i_rst;
        run_md  = i_run;
        disp_md = i_dmd;
        clr_on  = i_clr;
`ifdef STOPWATCH_LAP_EN
        lap     = i_lap;
`endif
        en        = i_run && !i_clr;
        e.chk     = m_known;
        e.tick    = !i_rst && en && (m_phase == PRESC - 1);
        e.running = m_run;
        e.ovf     = m_ovf;
        e.disp    = m_disp;
        e.lap_act = m_lap;
        exp_q.push_back(e);
        if (i_rst) begin
            m_phase = 0; m_centis = 0; m_snap = 0;
            m_ovf = 0; m_run = 0; m_lap = 0; m_disp = 16'h0000;
            m_known = 1;
        end else begin
            nl     = i_clr ? 1'b0 : (i_lap ? !m_lap : m_lap);
            m_disp = fmt((m_lap && nl) ? m_snap : m_centis, i_dmd);
            if (i_lap && !m_lap && !i_clr) m_snap = m_centis;
            m_run = en;
            if (i_clr) begin
                m_phase = 0; m_centis = 0; m_ovf = 0;
            end else if (en) begin
                if (m_phase == PRESC - 1) begin
                    m_phase = 0;
                    m_centis++;
                    if (m_centis == FULL) begin
                        m_centis = 0;
                        m_ovf    = 1;
                    end
                end else begin
                    m_phase++;
                end
            end
            m_lap = nl;
        end
    endtask

    task automatic run_n(input int n, input bit i_dmd);
        for (int i = 0; i < n; i++) cyc(0, 1, i_dmd, 0, 0);
    endtask

    // Paused for two cycles, then check the display on the second negedge.
    task automatic idle_chk(input string name, input bit i_dmd,
                            input logic [15:0] req);
        cyc(0, 0, i_dmd, 0, 0);
        cyc(0, 0, i_dmd, 0, 0);
        @(negedge clk);
        cmp(name, 32'(disp_bcd), 32'(req));
    endtask

    // Run until the DUT ticks (bounded) and check how many en cycles it took.
    task automatic wait_tick(input string name, input int req_n);
        int found;
        found = -1;
        for (int i = 1; i <= req_n + 10; i++) begin
            cyc(0, 1, 1, 0, 0);
            @(negedge clk);
            if (tick) begin
                found = i;
                break;
            end
        end
        cmp(name, 32'(found), 32'(req_n));
    endtask

    // Place the digit chain at 59:59.99 (sel=1) or 00:12.34 (sel=0) while
    // paused; the force is held across one edge so the flops keep the value.
    task automatic preload(input bit sel, input bit i_dmd);
        int v;
        v = sel ? 359999 : 1234;
        cyc(0, 0, i_dmd, 0, 0);
        #1;
        if (sel) begin
            force dut.min_t_q = 4'd5; force dut.min_o_q = 4'd9;
            force dut.sec_t_q = 4'd5; force dut.sec_o_q = 4'd9;
            force dut.cs_t_q  = 4'd9; force dut.cs_o_q  = 4'd9;
        end else begin
            force dut.min_t_q = 4'd0; force dut.min_o_q = 4'd0;
            force dut.sec_t_q = 4'd1; force dut.sec_o_q = 4'd2;
            force dut.cs_t_q  = 4'd3; force dut.cs_o_q  = 4'd4;
        end
        m_centis = v;
        m_disp   = fmt(v, i_dmd);
        cyc(0, 0, i_dmd, 0, 0);
        #1;
        release dut.min_t_q; release dut.min_o_q;
        release dut.sec_t_q; release dut.sec_o_q;
        release dut.cs_t_q;  release dut.cs_o_q;
    endtask

    // Scoreboard monitor: one expected entry per cycle, compared at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tick) n_ticks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    cmp("sb_tick",    32'(tick),     32'(e.tick));
                    cmp("sb_running", 32'(running),  32'(e.running));
                    cmp("sb_ovf",     32'(ovf),      32'(e.ovf));
                    cmp("sb_disp",    32'(disp_bcd), 32'(e.disp));
`ifdef STOPWATCH_LAP_EN
                    cmp("sb_lap_act", 32'(lap_act),  32'(e.lap_act));
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        // Reset and reset values
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        cmp("rst_disp",    32'(disp_bcd), 32'h0);
        cmp("rst_running", 32'(running),  32'h0);
        cmp("rst_ovf",     32'(ovf),      32'h0);
        cmp("rst_tick",    32'(tick),     32'h0);

        // 100 run cycles -> 10 ticks, 00:00.10
        t0 = n_ticks;
        run_n(100, 1);
        idle_chk("disp_0010", 1, 16'h0010);
        cmp("ticks_in_100", 32'(n_ticks - t0), 32'd10);
        idle_chk("disp_0000_mmss", 0, 16'h0000);

        // Carry from 00:00.99 into 00:01.00
        run_n(890, 1);
        idle_chk("disp_0099", 1, 16'h0099);
        run_n(10, 1);
        idle_chk("disp_0100", 1, 16'h0100);
        idle_chk("disp_0001_mmss", 0, 16'h0001);

        // Pause keeps the prescaler phase
        run_n(3, 1);
        cyc(0, 0, 1, 0, 0);
        @(negedge clk);
        cmp("running_lat_hi", 32'(running), 32'h1);
        cyc(0, 0, 1, 0, 0);
        @(negedge clk);
        cmp("running_lat_lo", 32'(running), 32'h0);
        for (int i = 0; i < 48; i++) cyc(0, 0, 1, 0, 0);
        wait_tick("resume_first_tick", 7);

        // Full wrap, overflow and clear
        preload(1, 0);
        idle_chk("disp_5959", 0, 16'h5959);
        idle_chk("disp_5999", 1, 16'h5999);
        run_n(10, 1);
        idle_chk("wrap_disp_sscc", 1, 16'h0000);
        idle_chk("wrap_disp_mmss", 0, 16'h0000);
        cmp("wrap_ovf", 32'(ovf), 32'h1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        cmp("clr_ovf", 32'(ovf), 32'h0);
        t0 = n_ticks;
        for (int i = 0; i < 30; i++) cyc(0, 1, 1, 1, 0);
        @(negedge clk);
        #1;
        cmp("clr_no_ticks", 32'(n_ticks - t0), 32'd0);
        cmp("clr_running",  32'(running), 32'h0);
        wait_tick("clr_release_first_tick", PRESC);

        // Reset in the middle of a count with ovf set
        preload(1, 1);
        run_n(10, 1);
        preload(0, 1);
        run_n(5, 1);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        @(negedge clk);
        cmp("midrst_disp",    32'(disp_bcd), 32'h0);
        cmp("midrst_ovf",     32'(ovf),      32'h0);
        cmp("midrst_running", 32'(running),  32'h0);
        wait_tick("midrst_first_tick", PRESC - 1);

`ifdef STOPWATCH_LAP_EN
        // Lap freeze and release
        cyc(1, 0, 1, 0, 0);
        run_n(500, 1);
        cyc(0, 1, 1, 0, 1);
        run_n(499, 1);
        @(negedge clk);
        cmp("lap_frozen_disp", 32'(disp_bcd), 32'h0050);
        cmp("lap_act_on",      32'(lap_act),  32'h1);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 0);
        @(negedge clk);
        cmp("lap_release_disp", 32'(disp_bcd), 32'h0100);
        cmp("lap_act_off",      32'(lap_act),  32'h0);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_run, r_dmd, r_clr, r_lap;
            r_rst = ($urandom_range(0, 399) == 0);
            r_clr = ($urandom_range(0, 59) == 0);
            r_run = ($urandom_range(0, 9) < 8);
            r_dmd = 1'($urandom_range(0, 1));
`ifdef STOPWATCH_LAP_EN
            r_lap = ($urandom_range(0, 39) == 0);
`else
            r_lap = 1'b0;
`endif
            cyc(r_rst, r_run, r_dmd, r_clr, r_lap);
        end

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        cmp("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Time-keeping datapath driven by the button state controller's mode levels: run/pause, display select and clear.
- Runs a centisecond prescaler and a BCD min:sec.cs counter chain.
- Presents a registered 4-digit BCD word to the 7-segment scan driver, plus status flags back to the LEDs.
- Sits between the mode controller and the FND display mux, all in the 100 MHz domain.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 100, counter tick rate in Hz (centiseconds).
- PRESC, CLK_HZ/TICK_HZ, derived prescaler terminal count; must be >= 2.

Ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  synchronous active-high reset.
- run_md  input  1  level; 1 = counting, 0 = paused.
- disp_md  input  1  level; 0 = show MM:SS, 1 = show SS:CC.
- clr_on  input  1  level; 1 = hold all time state at zero.
- disp_bcd  output  16  {d3,d2,d1,d0}, 4-bit BCD per digit, d3 leftmost.
- tick  output  1  one-cycle pulse on every centisecond increment.
- running  output  1  1 while counting is enabled (run_md & ~clr_on).
- ovf  output  1  sticky flag, set when count wraps 59:59.99 -> 00:00.00.

Behaviour:
- Single clock domain. rst is sampled on posedge clk only: synchronous, active-high.
- Reset values:
  - prescaler = 0, all BCD digits = 0.
  - disp_bcd = 16'h0000.
  - tick = 0, running = 0, ovf = 0.
- Enable: en = run_md & ~clr_on.
- Prescaler, width $clog2(PRESC):
  - When en = 1, it counts 0..PRESC-1.
  - At PRESC-1 it wraps to 0, and tick is asserted for that same cycle (combinational from the terminal count, gated by en).
  - When en = 0, it holds its value; pause does not reset the sub-tick phase.
- Counter chain, advanced only on tick:
  - cs_o 0-9 carries into cs_t 0-9.
  - cs_t carries into sec_o 0-9, which carries into sec_t 0-5.
  - sec_t carries into min_o 0-9, which carries into min_t 0-5.
  - Each digit wraps to 0 and carries into the next digit on the same tick.
  - No digit ever holds a value > 9, or > 5 for the tens digits.
- Full wrap: tick at 59:59.99 sets all digits to 0 and sets ovf = 1. ovf then stays 1 until cleared.
- Clear:
  - While clr_on = 1, prescaler, all digits and ovf are forced to 0 every cycle.
  - Clear overrides run_md; if both are 1, counting does not occur and running = 0.
  - Releasing clr_on with run_md = 1 starts counting from prescaler 0, so the first tick comes PRESC cycles later.
- running is registered: running <= en, giving 1 cycle latency.
- Display:
  - disp_bcd is registered, 1 cycle after the digit update.
  - disp_md = 0 selects {min_t,min_o,sec_t,sec_o}.
  - disp_md = 1 selects {sec_t,sec_o,cs_t,cs_o}.
  - A disp_md change takes effect in disp_bcd on the next clock. It has no effect on counting.
- Reset mid-count: everything returns to reset values on the next edge, overriding all other inputs.
- Pause/resume: holding run_md = 0 for any duration and then returning to 1 produces no lost or extra tick. The total en-high cycles between ticks is always exactly PRESC.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- When defined, add input port lap (1-bit, single-cycle pulse, already edge-detected upstream) and output lap_act (1-bit).
  - A lap pulse while lap_act = 0 sets lap_act = 1 and freezes disp_bcd at its current source digits.
  - While frozen, the counter chain keeps running and disp_md still selects which pair of frozen digits is shown. A snapshot of all six digits is taken on the lap pulse.
  - The next lap pulse clears lap_act, and disp_bcd returns to live digits on the following cycle.
  - clr_on = 1 or rst also clears lap_act.
- When undefined, lap and lap_act do not exist and disp_bcd always shows live digits.

Test Plan:
- Bench setup: CLK_HZ=1000, TICK_HZ=100, so PRESC=10.
- Reset, then run_md=1 for 100 cycles -> exactly 10 tick pulses, 10 cycles apart. With disp_md=1, disp_bcd=16'h0010; with disp_md=0, 16'h0000.
- Count to 00:00.99 (990 en cycles), then 10 more -> with disp_md=1, disp_bcd goes 16'h0099 -> 16'h0100; with disp_md=0, 16'h0001 after the carry.
- Run 3 cycles, run_md=0 for 50 cycles, run_md=1 -> the first tick arrives 7 en cycles after resume; running drops 1 cycle after pause.
- Preload by running to 59:59.99, then 10 more cycles -> all digits 0, ovf=1. Assert clr_on=1 for 1 cycle -> ovf=0. Assert clr_on=1 together with run_md=1 -> no ticks and running=0.
- Assert rst mid-count at 00:12.34 -> on the next edge disp_bcd=0, ovf=0, running=0. The first tick comes 10 cycles after rst deasserts with run_md=1.
- STOPWATCH_LAP_EN, with disp_md=1:
  - lap at 00:00.50 -> lap_act=1 and disp_bcd holds 16'h0050 while the count reaches 00:01.00.
  - The second lap -> disp_bcd=16'h0100 the next cycle.
